// File: rtl/bzled_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bzled_pkg
// Brief    : Shared encodings for the BZLED pattern sequencer: FSM states,
//            colour channels and the data width used by perip_BZLED.
// Revision : 1.0 - initial release
// ============================================================================
package bzled_pkg;

    // Data width of every period/duty word exchanged with perip_BZLED
    localparam int BZLED_DW = 32;

    // FSM state encoding (also visible on the debug port)
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] c_ST_RAMP_DOWN = 2'd2;
    localparam logic [1:0] c_ST_BEEP      = 2'd3;

    // Colour channel encoding, swept in this order
    localparam logic [1:0] c_CH_R = 2'd0;
    localparam logic [1:0] c_CH_G = 2'd1;
    localparam logic [1:0] c_CH_B = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bzled_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : bzled_tick_gen
// Brief    : Ramp prescaler. Counts 0..TICK_DIV-1 while running and not held,
//            strobes tick on the wrap cycle, clears whenever not running.
// Revision : 1.0 - initial release
// ============================================================================
module bzled_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int unsigned         c_CNT_W  = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0]  c_LAST   = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE    = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    // The strobe is decoded from the count so the FSM acts on the same edge
    // the count wraps, giving exactly TICK_DIV cycles from FSM entry to the
    // first update.
    assign w_wrap = run && !hold && (r_cnt == c_LAST);
    assign tick   = w_wrap;

    // Prescaler count: cleared when idle, frozen while held, wraps at TICK_DIV
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (!hold) begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bzled_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : bzled_pattern_seq
// Brief    : R->G->B breathing sweep with a triangular duty ramp per colour,
//            followed by a timed buzzer beep and a one-cycle done pulse.
//            Drives the period/duty inputs of perip_BZLED.
// Revision : 1.0 - initial release
// ============================================================================
module bzled_pattern_seq
    import bzled_pkg::*;
#(
    parameter int unsigned          TICK_DIV    = 50000,
    parameter logic [BZLED_DW-1:0]  LED_PERIOD  = 32'd10000,
    parameter logic [BZLED_DW-1:0]  STEP        = 32'd100,
    parameter logic [BZLED_DW-1:0]  BEEP_PERIOD = 32'd10000,
    parameter int unsigned          BEEP_TICKS  = 100
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                en,
    input  logic                pause,
    output logic [BZLED_DW-1:0] LED_FREQ_Set,
    output logic [BZLED_DW-1:0] BZ_FREQ_Set,
    output logic [BZLED_DW-1:0] LEDR_Puty_Set,
    output logic [BZLED_DW-1:0] LEDG_Puty_Set,
    output logic [BZLED_DW-1:0] LEDB_Puty_Set,
    output logic                cycle_done,
    output logic [1:0]          state_o
);

    localparam int unsigned        c_BC_W    = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [c_BC_W-1:0]  c_BC_LAST = c_BC_W'(BEEP_TICKS - 1);
    localparam logic [c_BC_W-1:0]  c_BC_ONE  = c_BC_W'(1);

    // Registered state
    logic [1:0]          r_state;
    logic [1:0]          r_chan;
    logic [BZLED_DW-1:0] r_duty_r;
    logic [BZLED_DW-1:0] r_duty_g;
    logic [BZLED_DW-1:0] r_duty_b;
    logic [BZLED_DW-1:0] r_bz;
    logic                r_cycle_done;
    logic [c_BC_W-1:0]   r_beep_cnt;

    // Next-state values
    logic [1:0]          w_state_nxt;
    logic [1:0]          w_chan_nxt;
    logic [BZLED_DW-1:0] w_duty_r_nxt;
    logic [BZLED_DW-1:0] w_duty_g_nxt;
    logic [BZLED_DW-1:0] w_duty_b_nxt;
    logic [BZLED_DW-1:0] w_bz_nxt;
    logic                w_done_nxt;
    logic [c_BC_W-1:0]   w_beep_nxt;

    // Ramp arithmetic on the active channel
    logic                w_tick;
    logic [BZLED_DW-1:0] w_active;
    logic [BZLED_DW:0]   w_sum;
    logic [BZLED_DW-1:0] w_up;
    logic [BZLED_DW-1:0] w_dn;

    bzled_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK   (CLK),
        .RST_n (RST_n),
        .run   (r_state != c_ST_IDLE),
        .hold  (pause),
        .tick  (w_tick)
    );

    // Select the duty of the channel currently being swept
    always_comb begin
        w_active = '0;
        case (r_chan)
            c_CH_R:  w_active = r_duty_r;
            c_CH_G:  w_active = r_duty_g;
            c_CH_B:  w_active = r_duty_b;
            default: w_active = '0;
        endcase
    end

    // Saturating step up (one extra bit so a large STEP cannot wrap) and
    // clamped step down
    assign w_sum = {1'b0, w_active} + {1'b0, STEP};
    assign w_up  = (w_sum >= {1'b0, LED_PERIOD}) ? LED_PERIOD : w_sum[BZLED_DW-1:0];
    assign w_dn  = (w_active <= STEP) ? '0 : (w_active - STEP);

    // Next-state and next-output decode; en low beats both tick and pause
    always_comb begin
        w_state_nxt  = r_state;
        w_chan_nxt   = r_chan;
        w_duty_r_nxt = r_duty_r;
        w_duty_g_nxt = r_duty_g;
        w_duty_b_nxt = r_duty_b;
        w_bz_nxt     = r_bz;
        w_done_nxt   = 1'b0;
        w_beep_nxt   = r_beep_cnt;

        if (r_state == c_ST_IDLE || !en) begin
            w_duty_r_nxt = '0;
            w_duty_g_nxt = '0;
            w_duty_b_nxt = '0;
            w_bz_nxt     = '0;
            w_chan_nxt   = c_CH_R;
            w_beep_nxt   = '0;
            w_state_nxt  = (r_state == c_ST_IDLE && en) ? c_ST_RAMP_UP : c_ST_IDLE;
        end else if (w_tick) begin
            case (r_state)
                c_ST_RAMP_UP: begin
                    case (r_chan)
                        c_CH_R:  w_duty_r_nxt = w_up;
                        c_CH_G:  w_duty_g_nxt = w_up;
                        default: w_duty_b_nxt = w_up;
                    endcase
                    if (w_up == LED_PERIOD) begin
                        w_state_nxt = c_ST_RAMP_DOWN;
                    end
                end
                c_ST_RAMP_DOWN: begin
                    case (r_chan)
                        c_CH_R:  w_duty_r_nxt = w_dn;
                        c_CH_G:  w_duty_g_nxt = w_dn;
                        default: w_duty_b_nxt = w_dn;
                    endcase
                    if (w_dn == '0) begin
                        if (r_chan == c_CH_B) begin
                            w_state_nxt = c_ST_BEEP;
                            w_chan_nxt  = c_CH_R;
                            w_bz_nxt    = BEEP_PERIOD;
                            w_beep_nxt  = '0;
                        end else begin
                            w_state_nxt = c_ST_RAMP_UP;
                            w_chan_nxt  = r_chan + 2'd1;
                        end
                    end
                end
                c_ST_BEEP: begin
                    if (r_beep_cnt == c_BC_LAST) begin
                        w_bz_nxt    = '0;
                        w_done_nxt  = 1'b1;
                        w_beep_nxt  = '0;
                        w_state_nxt = c_ST_RAMP_UP;
                    end else begin
                        w_beep_nxt  = r_beep_cnt + c_BC_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state      <= c_ST_IDLE;
            r_chan       <= c_CH_R;
            r_duty_r     <= '0;
            r_duty_g     <= '0;
            r_duty_b     <= '0;
            r_bz         <= '0;
            r_cycle_done <= 1'b0;
            r_beep_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_chan       <= w_chan_nxt;
            r_duty_r     <= w_duty_r_nxt;
            r_duty_g     <= w_duty_g_nxt;
            r_duty_b     <= w_duty_b_nxt;
            r_bz         <= w_bz_nxt;
            r_cycle_done <= w_done_nxt;
            r_beep_cnt   <= w_beep_nxt;
        end
    end

    assign LED_FREQ_Set  = LED_PERIOD;
    assign BZ_FREQ_Set   = r_bz;
    assign LEDR_Puty_Set = r_duty_r;
    assign LEDG_Puty_Set = r_duty_g;
    assign LEDB_Puty_Set = r_duty_b;
    assign cycle_done    = r_cycle_done;
    assign state_o       = r_state;

endmodule
`default_nettype wire
